seq_mag_comp: RTL and testbench
===============================

// Module: seq_mag_comp
// PURPOSE
//   Parametrised, multi-cycle magnitude comparator: successor to the fixed 4-bit
//   combinational less/equal/more comparator.
//   - Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, with
//     early termination on the first differing chunk.
//   - Supports unsigned and two's-complement signed modes.
//   - Sits between valid/ready producers and consumers in datapaths where a wide
//     single-cycle compare would not meet timing.
// PARAMETERS
//   WIDTH      16  operand width in bits; must be a multiple of CHUNK
//   CHUNK      4   bits compared per cycle; NCH = WIDTH/CHUNK chunks
//   SIGNED_EN  1   1: signed_mode input honoured; 0: signed_mode ignored (unsigned only)
// PORTS
//   clk          in   1                 clock, rising edge
//   rst          in   1                 reset, asynchronous, active-high
//   in_valid     in   1                 operands/mode valid
//   in_ready     out  1                 block can accept operands
//   a            in   WIDTH             operand A
//   b            in   WIDTH             operand B
//   signed_mode  in   1                 1: compare as two's complement
//   out_valid    out  1                 result valid
//   out_ready    in   1                 consumer takes result
//   lt           out  1                 A < B
//   eq           out  1                 A == B
//   gt           out  1                 A > B
//   used_chunks  out  $clog2(NCH+1)     chunks examined for this result (1..NCH)
// BEHAVIOUR
//   - One clock, clk. rst is asynchronous and active-high.
//   - Reset state: IDLE; out_valid=0, lt=eq=gt=0, used_chunks=0, chunk index=NCH-1.
//   - in_ready = (state==IDLE), combinational. in_valid is ignored while rst is high.
//   - FSM IDLE -> CMP -> DONE -> IDLE:
//     - IDLE: on in_valid&&in_ready at an edge, register a, b and
//       (signed_mode&&SIGNED_EN); idx=NCH-1; go to CMP.
//     - CMP, one chunk per cycle:
//       - Chunk idx is bits [idx*CHUNK +: CHUNK].
//       - If signed and idx==NCH-1, invert the MSB of both A and B chunks before
//         comparing (converts to unsigned order).
//       - Chunks differ: set gt or lt from the unsigned chunk compare,
//         used_chunks=NCH-idx, go to DONE.
//       - Chunks equal and idx==0: eq=1, used_chunks=NCH, go to DONE.
//       - Otherwise idx=idx-1 and stay in CMP.
//     - DONE: out_valid=1; lt/eq/gt/used_chunks held stable; exactly one of lt/eq/gt
//       is 1. On out_valid&&out_ready: clear out_valid and lt/eq/gt, go to IDLE.
//   - Latency: acceptance at edge T0 -> out_valid high after edge T0+k, where
//     k=used_chunks (min 1, max NCH).
//   - Throughput: next operand accepted no earlier than the edge after the result
//     handshake.
//   - Backpressure: out_ready low holds DONE indefinitely; in_ready stays 0 and
//     in_valid is not sampled.
//   - Operand/mode changes on the inputs after acceptance have no effect on the
//     result in flight.
//   - rst asserted in any state, including mid-CMP or in DONE: immediately return to
//     reset values; the in-flight result is discarded and never presented.
//   - lt/eq/gt are 0 whenever out_valid=0.
//   - Edge cases:
//     - CHUNK==WIDTH: NCH=1, single-cycle compare.
//     - signed a=MIN vs b=MAX: lt.
//     - a==b==0: eq, used_chunks=NCH.
// TESTING (WIDTH=16, CHUNK=4, SIGNED_EN=1, out_ready=1 unless stated)
//   1. a=16'h1234, b=16'h1234, unsigned -> eq=1, lt=gt=0, used_chunks=4,
//      out_valid 4 edges after accept.
//   2. a=16'hA000, b=16'h1FFF, unsigned -> gt=1, used_chunks=1, out_valid 1 edge after accept.
//   3. a=16'hA000, b=16'h1FFF, signed -> lt=1, used_chunks=1.
//   4. a=16'h1235, b=16'h1234, unsigned -> gt=1, used_chunks=4.
//      Also a=16'hFFFF, b=16'h0000, signed -> lt=1, used_chunks=1.
//   5. Case 1 with out_ready=0 for 5 cycles, new in_valid pulsed meanwhile ->
//      outputs stable, in_ready=0, second operand not taken. out_ready=1 -> out_valid
//      drops next edge, in_ready=1.
//   6. rst pulsed (asynchronously, mid-cycle) during CMP of case 4 -> out_valid=0,
//      lt=eq=gt=0, in_ready=1 immediately. No result is ever presented. Next compare
//      is correct.

Source files
------------

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands CHUNK bits
// per cycle, MSB chunk first, stopping at the first differing chunk.
module seq_mag_comp #(
    parameter int WIDTH     = 16,
    parameter int CHUNK     = 4,
    parameter int SIGNED_EN = 1,
    localparam int NCH      = WIDTH / CHUNK,
    localparam int UW       = $clog2(NCH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [UW-1:0]    used_chunks
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_q, a_nxt;
    logic [WIDTH-1:0]  b_q, b_nxt;
    logic              sgn_q, sgn_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic              lt_nxt, eq_nxt, gt_nxt;
    logic [UW-1:0]     used_nxt;
    logic [CHUNK-1:0]  ca, cb;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Select the current chunk; in signed mode the top chunk has its sign bit
    // flipped so that an unsigned compare gives two's-complement order.
    always_comb begin
        ca = '0;
        cb = '0;
        for (int i = 0; i < NCH; i++) begin
            if (idx == IW'(i)) begin
                ca = a_q[i*CHUNK +: CHUNK];
                cb = b_q[i*CHUNK +: CHUNK];
            end
        end
        if (sgn_q && (idx == IW'(NCH - 1))) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        sgn_nxt   = sgn_q;
        idx_nxt   = idx;
        lt_nxt    = lt;
        eq_nxt    = eq;
        gt_nxt    = gt;
        used_nxt  = used_chunks;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    sgn_nxt   = signed_mode && (SIGNED_EN != 0);
                    idx_nxt   = IW'(NCH - 1);
                    state_nxt = CMP;
                end
            end
            CMP: begin
                if (ca != cb) begin
                    gt_nxt    = (ca > cb);
                    lt_nxt    = (ca < cb);
                    used_nxt  = UW'(NCH - int'(idx));
                    state_nxt = DONE;
                end else if (idx == '0) begin
                    eq_nxt    = 1'b1;
                    used_nxt  = UW'(NCH);
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx - IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    lt_nxt    = 1'b0;
                    eq_nxt    = 1'b0;
                    gt_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values of the previous cycle regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            idx         <= IW'(NCH - 1);
            lt          <= 1'b0;
            eq          <= 1'b0;
            gt          <= 1'b0;
            used_chunks <= '0;
        end else begin
            state       <= state_nxt;
            a_q         <= a_nxt;
            b_q         <= b_nxt;
            sgn_q       <= sgn_nxt;
            idx         <= idx_nxt;
            lt          <= lt_nxt;
            eq          <= eq_nxt;
            gt          <= gt_nxt;
            used_chunks <= used_nxt;
        end
    end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Self-checking bench for seq_mag_comp: directed cases plus randomized
// operands checked against an arithmetic reference model.
module tb_seq_mag_comp;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int N  = W / C;
    localparam int UW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          signed_mode;
    logic          out_valid;
    logic          out_ready;
    logic          lt, eq, gt;
    logic [UW-1:0] used_chunks;

    int n_cmp = 0;
    int n_bad = 0;

    seq_mag_comp #(.WIDTH(W), .CHUNK(C), .SIGNED_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .lt         (lt),
        .eq         (eq),
        .gt         (gt),
        .used_chunks(used_chunks)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic for the verdict; chunks used is
    // fixed by the highest differing bit position.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic sm,
                         output logic elt, output logic eeq, output logic egt, output int eused);
        logic [W-1:0] d;
        int p;
        if (sm) begin
            elt = $signed(ma) < $signed(mb);
            egt = $signed(ma) > $signed(mb);
        end else begin
            elt = ma < mb;
            egt = ma > mb;
        end
        eeq = (ma == mb);
        d = ma ^ mb;
        p = -1;
        for (int i = 0; i < W; i++) if (d[i]) p = i;
        eused = (p < 0) ? N : N - (p / C);
    endtask

    // Issue one compare; hold = cycles out_ready stays low once the result is up,
    // during which competing in_valid pulses must be ignored.
    task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic sm,
                           input int hold, input string tag);
        logic elt, eeq, egt;
        int eused;
        int cyc;
        model(ta, tb_v, sm, elt, eeq, egt, eused);
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        a = ta;
        b = tb_v;
        signed_mode = sm;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        signed_mode = ~sm;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!out_valid && cyc < N + 4);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".latency"}, 32'(cyc), 32'(eused));
        check({tag, ".lt_eq_gt"}, 32'({lt, eq, gt}), 32'({elt, eeq, egt}));
        check({tag, ".used"}, 32'(used_chunks), 32'(eused));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".hold_flags"}, 32'({lt, eq, gt, used_chunks}),
                  32'({elt, eeq, egt, UW'(eused)}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".cleared"}, 32'({lt, eq, gt}), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        out_ready = 1'b1;
        #12;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.flags", 32'({lt, eq, gt}), 32'd0);
        check("reset.used", 32'(used_chunks), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_cmp(16'h1234, 16'h1234, 1'b0, 0, "c1_eq");
        run_cmp(16'hA000, 16'h1FFF, 1'b0, 0, "c2_ugt");
        run_cmp(16'hA000, 16'h1FFF, 1'b1, 0, "c3_slt");
        run_cmp(16'h1235, 16'h1234, 1'b0, 0, "c4_ugt");
        run_cmp(16'hFFFF, 16'h0000, 1'b1, 0, "c4_slt");
        run_cmp(16'h8000, 16'h7FFF, 1'b1, 0, "min_max");
        run_cmp(16'h0000, 16'h0000, 1'b1, 0, "zero");
        run_cmp(16'h1234, 16'h1234, 1'b0, 5, "c5_bp");

        // Asynchronous reset in the middle of a compare discards the result.
        @(negedge clk);
        a = 16'h1235;
        b = 16'h1234;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("c6.out_valid", 32'(out_valid), 32'd0);
        check("c6.in_ready", 32'(in_ready), 32'd1);
        check("c6.flags", 32'({lt, eq, gt}), 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            check("c6.no_result", 32'(out_valid), 32'd0);
        end
        run_cmp(16'h1235, 16'h1234, 1'b0, 0, "c6_after");

        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0: rb = W'($urandom);
                1: rb = ra;
                2: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = ra ^ W'($urandom_range(1, 15) << (C * $urandom_range(0, N - 1)));
            endcase
            run_cmp(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
